// File: rtl/morse_pkg.sv
// Shared Morse decoder definitions.
//   SYM_W_DEF  : default bits per segment symbol
//   DEPTH_DEF  : default display slots (8-digit panel)
//   BLANK_SEG  : segment code meaning "digit off"
//   buf_op_e   : the single operation a symbol buffer commits on a clock edge
package morse_pkg;

  localparam int SYM_W_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam logic [7:0] BLANK_SEG = 8'h00;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLR,
    OP_DEL,
    OP_PUSH
  } buf_op_e;

endpackage

// File: rtl/symbol_shift_buffer.sv
// Display-line buffer between the symbol decoder and the 7-seg scan driver.
// New symbols enter at slot 0 (LSB) and older ones move toward slot DEPTH-1.
// Supports backspace, clear, occupancy count and a stop/scroll full policy.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   sym_in     : symbol to append, sym_valid/sym_ready handshake
//   del_req    : drop the newest symbol (backspace)
//   clr        : blank the whole line
//   buf_out    : slot k at [k*SYM_W +: SYM_W], slot 0 newest
//   count      : valid symbols, 0..DEPTH; full/empty derived from it
//   overflow   : sticky, push attempted while full with SCROLL=0
//   del_err    : one-cycle pulse after a backspace on an empty line
module symbol_shift_buffer
  import morse_pkg::*;
#(
  parameter int               SYM_W  = SYM_W_DEF,
  parameter int               DEPTH  = DEPTH_DEF,
  parameter logic [SYM_W-1:0] BLANK  = SYM_W'(BLANK_SEG),
  parameter bit               SCROLL = 1'b0,
  localparam int              CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SYM_W-1:0]       sym_in,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic                   del_req,
  input  logic                   clr,
  output logic [SYM_W*DEPTH-1:0] buf_out,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   del_err
);

  logic [SYM_W-1:0] slot_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             del_err_q;
  buf_op_e          op;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign sym_ready = ~rst & ~clr & ~del_req & (~full | SCROLL);

  // Priority clr > del > push; rst is handled directly in the register block.
  always_comb begin
    op = OP_NONE;
    if (clr)
      op = OP_CLR;
    else if (del_req)
      op = OP_DEL;
    else if (sym_valid && sym_ready)
      op = OP_PUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= BLANK;
      count_q    <= '0;
      overflow_q <= 1'b0;
      del_err_q  <= 1'b0;
    end else begin
      del_err_q <= (op == OP_DEL) && empty;
      case (op)
        OP_CLR: begin
          for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= BLANK;
          count_q    <= '0;
          overflow_q <= 1'b0;
        end
        OP_DEL: begin
          // Slots above count are already BLANK, so a plain shift keeps the invariant.
          if (!empty) begin
            for (int unsigned k = 0; k < DEPTH - 1; k++) slot_q[k] <= slot_q[k+1];
            slot_q[DEPTH-1] <= BLANK;
            count_q         <= count_q - CNT_W'(1);
          end
        end
        OP_PUSH: begin
          for (int unsigned k = 1; k < DEPTH; k++) slot_q[k] <= slot_q[k-1];
          slot_q[0] <= sym_in;
          if (!full) count_q <= count_q + CNT_W'(1);
        end
        default: begin
          // No commit: a valid push was refused only because the line is full.
          if (sym_valid && full && !SCROLL) overflow_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    buf_out = '0;
    for (int unsigned k = 0; k < DEPTH; k++) buf_out[k*SYM_W +: SYM_W] = slot_q[k];
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign del_err  = del_err_q;

endmodule

// File: tb/tb_symbol_shift_buffer.sv
module tb_symbol_shift_buffer;

  typedef logic [7:0] sym_t;

  typedef struct {
    logic [63:0] buf_v [2];
    int          cnt   [2];
    bit          ovf   [2];
    bit          derr  [2];
    bit          rdy   [2];
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sym_in = '0;
  logic        sym_valid = 1'b0;
  logic        del_req = 1'b0;
  logic        clr = 1'b0;

  logic        rdy  [2];
  logic [63:0] bufo [2];
  logic [3:0]  cnt  [2];
  logic        full [2];
  logic        empt [2];
  logic        ovf  [2];
  logic        derr [2];

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // reference model state: queue index 0 is the newest symbol
  sym_t mq0[$];
  sym_t mq1[$];
  bit   m_ovf  [2];
  bit   m_derr [2];

  always #5 clk = ~clk;

  symbol_shift_buffer #(.SYM_W(8), .DEPTH(8), .BLANK(8'h00), .SCROLL(1'b0)) dut_stop (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(rdy[0]),
    .del_req(del_req), .clr(clr), .buf_out(bufo[0]), .count(cnt[0]), .full(full[0]),
    .empty(empt[0]), .overflow(ovf[0]), .del_err(derr[0]));

  symbol_shift_buffer #(.SYM_W(8), .DEPTH(8), .BLANK(8'h00), .SCROLL(1'b1)) dut_scroll (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(rdy[1]),
    .del_req(del_req), .clr(clr), .buf_out(bufo[1]), .count(cnt[1]), .full(full[1]),
    .empty(empt[1]), .overflow(ovf[1]), .del_err(derr[1]));

  function automatic logic [63:0] line_of(input sym_t q[$]);
    logic [63:0] r = '0;
    for (int k = 0; k < q.size(); k++) r[k*8 +: 8] = q[k];
    return r;
  endfunction

  task automatic model_step(input sym_t qi[$], output sym_t qo[$], inout bit o, inout bit d,
                            input bit scroll, input bit r, input bit c, input bit dl,
                            input bit v, input sym_t s);
    qo = qi;
    if (r || c) begin
      qo.delete();
      o = 1'b0;
      d = 1'b0;
    end else if (dl) begin
      d = (qo.size() == 0);
      if (qo.size() > 0) void'(qo.pop_front());
    end else begin
      d = 1'b0;
      if (v) begin
        if (qo.size() < 8) qo.push_front(s);
        else if (scroll) begin
          qo.push_front(s);
          void'(qo.pop_back());
        end else o = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, record what the DUTs must show during it,
  // then advance the model to the post-edge state.
  task automatic cycle(input bit r, input bit c, input bit dl, input bit v, input sym_t s);
    exp_t e;
    sym_t nq[$];
    @(posedge clk);
    #1;
    rst = r; clr = c; del_req = dl; sym_valid = v; sym_in = s;
    e.buf_v[0] = line_of(mq0);  e.buf_v[1] = line_of(mq1);
    e.cnt[0]   = mq0.size();    e.cnt[1]   = mq1.size();
    e.ovf[0]   = m_ovf[0];      e.ovf[1]   = m_ovf[1];
    e.derr[0]  = m_derr[0];     e.derr[1]  = m_derr[1];
    e.rdy[0]   = !r && !c && !dl && (mq0.size() < 8);
    e.rdy[1]   = !r && !c && !dl;
    exp_q.push_back(e);
    model_step(mq0, nq, m_ovf[0], m_derr[0], 1'b0, r, c, dl, v, s); mq0 = nq;
    model_step(mq1, nq, m_ovf[1], m_derr[1], 1'b1, r, c, dl, v, s); mq1 = nq;
  endtask

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h at %0t", name, i, act, req, $time);
    end
  endtask

  // monitor: mid-cycle, compares DUT outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk("buf_out",   i, bufo[i],         e.buf_v[i]);
          chk("count",     i, 64'(cnt[i]),     64'(e.cnt[i]));
          chk("full",      i, 64'(full[i]),    64'(e.cnt[i] == 8));
          chk("empty",     i, 64'(empt[i]),    64'(e.cnt[i] == 0));
          chk("overflow",  i, 64'(ovf[i]),     64'(e.ovf[i]));
          chk("del_err",   i, 64'(derr[i]),    64'(e.derr[i]));
          chk("sym_ready", i, 64'(rdy[i]),     64'(e.rdy[i]));
        end
      end
    end
  end

  initial begin
    m_ovf  = '{1'b0, 1'b0};
    m_derr = '{1'b0, 1'b0};
    rst = 1'b1;
    repeat (2) @(posedge clk);

    cycle(1, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 1, 8'hA1);
    cycle(0, 0, 0, 1, 8'hB2);
    cycle(0, 0, 0, 1, 8'hC3);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 1, 8'h55);
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 1, 8'h77);
    cycle(0, 1, 1, 1, 8'h88);
    for (int n = 1; n <= 9; n++) cycle(0, 0, 0, 1, 8'(n));
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 1, 8'h0A);
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 1, 8'h31);
    cycle(0, 0, 0, 1, 8'h32);
    cycle(1, 1, 1, 1, 8'h33);
    cycle(0, 0, 0, 0, 8'h00);

    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
    end
    cycle(0, 0, 0, 0, 8'h00);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
